branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Fetch-side controller that owns the program counter and sequences the Brancher unit.
- Accepts one instruction per cycle from decode. On a branch it drives the Brancher's BranchType, waits out the Brancher's registered latency, then either redirects the PC and flushes younger pipeline stages, or falls through.
- Sits between decode and the Brancher/fetch stage. It also keeps a saturating count of taken branches for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment per accepted non-redirecting instruction.
- FLUSH_CYCLES, 2, number of cycles FlushPipe stays high after a taken branch. Legal range is 1..15; 0 is illegal.
- COUNT_W, 16, width of TakenCount.

Ports:
- ClockInput  input  1  system clock; all state updates on the rising edge.
- ResetInput  input  1  asynchronous, active-high reset.
- IssueValid  input  1  decode presents an instruction this cycle.
- IssueBranchType  input  2  0 = none, 1 = unconditional, 3 = conditional, 2 = reserved (treated as none).
- IssueReady  output  1  controller accepts an instruction this cycle; the transfer occurs when IssueValid && IssueReady.
- BrancherType  output  2  registered; drives the Brancher's BranchType input.
- BranchSignal  input  1  from the Brancher; registered taken flag.
- BranchAddress  input  32  from the Brancher; registered target.
- PCValue  output  32  current PC; also drives the Brancher's PCAddress.
- StallFetch  output  1  fetch must hold while a branch resolves or a flush is in progress.
- FlushPipe  output  1  squash the IF/ID stages.
- TakenCount  output  COUNT_W  saturating count of taken branches.

Behaviour:
- Reset (asynchronous, any state, including mid-branch) forces:
  - state = RUN, PCValue = RESET_PC, BrancherType = 0, StallFetch = 0, FlushPipe = 0, TakenCount = 0, flush counter = 0.
  - The in-flight branch is dropped.
- IssueReady = 1 only in RUN (combinational from state). Outputs other than IssueReady are registered.
- State RUN:
  - Accepted type 1 or 3: BrancherType <= type, StallFetch <= 1, go to ISSUE. PC is held.
  - Accepted type 0 or 2: PCValue <= PCValue + PC_STEP, stay in RUN.
  - No transfer: hold.
- State ISSUE (1 cycle, while the Brancher latches): BrancherType <= 0, go to WAIT. PCValue stays stable so the Brancher sees the branch PC.
- State WAIT (1 cycle): sample BranchSignal and BranchAddress at the end of the cycle.
  - Taken: PCValue <= BranchAddress, FlushPipe <= 1, counter <= FLUSH_CYCLES-1, TakenCount += 1 (saturates at all-ones, no wrap), go to FLUSH.
  - Not taken: PCValue <= PCValue + PC_STEP, StallFetch <= 0, go to RUN.
- State FLUSH:
  - While counter != 0, decrement it.
  - When counter == 0: FlushPipe <= 0, StallFetch <= 0, go to RUN.
  - FlushPipe is high for exactly FLUSH_CYCLES cycles.
- Latency measured from the acceptance edge k:
  - BrancherType is nonzero during cycle k..k+1.
  - The resolve decision is taken at edge k+2.
  - Not taken: the next acceptance is possible at edge k+3.
  - Taken: the next acceptance is possible at edge k+3+FLUSH_CYCLES.
- BranchSignal and BranchAddress are ignored outside WAIT.
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- A branch target is used verbatim, with no alignment check.
- IssueValid while IssueReady = 0 is not consumed; decode must hold it.

Test Plan:
1. Reset, then 3 back-to-back type-0 issues -> PCValue goes 0 -> 4 -> 8 -> 12; IssueReady is constantly 1; FlushPipe is never set.
2. PC = 16, type-1 issue, Brancher returns BranchSignal = 1 and BranchAddress = 32'h0000_0200 -> BrancherType = 1 for one cycle; PCValue = 32'h200 at edge k+2; FlushPipe high for 2 cycles; IssueReady returns at edge k+5; TakenCount = 1.
3. PC = 32, type-3 issue, BranchSignal = 0 -> PCValue = 36 at edge k+2; no flush; IssueReady = 1 at k+3; TakenCount unchanged.
4. Type-2 issue at PC = 8 -> treated as none; PCValue = 12; BrancherType stays 0.
5. ResetInput asserted mid-cycle during WAIT -> outputs return to reset values immediately (asynchronously); the BranchSignal = 1 that follows is ignored; PCValue = RESET_PC.
6. With COUNT_W = 2, take 5 branches -> TakenCount = 1, 2, 3, 3, 3 (saturates). Separately, PC = 32'hFFFF_FFFC with a type-0 issue -> PCValue = 0.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Decode / Brancher / fetch signal bundle for branch_sequencer.
// slave = the sequencer; master = the decode/Brancher/fetch side.
interface branch_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic               IssueValid;
  logic [1:0]         IssueBranchType;
  logic               IssueReady;
  logic [1:0]         BrancherType;
  logic               BranchSignal;
  logic [31:0]        BranchAddress;
  logic [31:0]        PCValue;
  logic               StallFetch;
  logic               FlushPipe;
  logic [COUNT_W-1:0] TakenCount;

  modport slave (
    input  IssueValid,
    input  IssueBranchType,
    input  BranchSignal,
    input  BranchAddress,
    output IssueReady,
    output BrancherType,
    output PCValue,
    output StallFetch,
    output FlushPipe,
    output TakenCount
  );

  modport master (
    output IssueValid,
    output IssueBranchType,
    output BranchSignal,
    output BranchAddress,
    input  IssueReady,
    input  BrancherType,
    input  PCValue,
    input  StallFetch,
    input  FlushPipe,
    input  TakenCount
  );
endinterface

// File: rtl/branch_sequencer.sv
// Fetch-side PC owner that sequences the Brancher unit.
// Ports: ClockInput, ResetInput (async high), bus (slave: issue, Brancher, fetch).
module branch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          PC_STEP      = 4,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          COUNT_W      = 16
) (
  input  logic ClockInput,
  input  logic ResetInput,
  branch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    RUN, ISSUE, WAIT, FLUSH
  } state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);
  localparam logic [3:0]  FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t             state;
  logic [31:0]        pcValue;
  logic [1:0]         brancherType;
  logic               stallFetch;
  logic               flushPipe;
  logic [COUNT_W-1:0] takenCount;
  logic [3:0]         flushCount;
  logic               accept;
  logic               isBranch;

  assign accept = bus.IssueValid && (state == RUN);
  // Types 1 and 3 are branches; 0 and reserved 2 share bit0 = 0.
  assign isBranch = bus.IssueBranchType[0];

  always_ff @(posedge ClockInput or posedge ResetInput) begin
    if (ResetInput) begin
      state        <= RUN;
      pcValue      <= RESET_PC;
      brancherType <= 2'd0;
      stallFetch   <= 1'b0;
      flushPipe    <= 1'b0;
      takenCount   <= '0;
      flushCount   <= 4'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept) begin
            if (isBranch) begin
              brancherType <= bus.IssueBranchType;
              stallFetch   <= 1'b1;
              state        <= ISSUE;
            end else begin
              pcValue <= pcValue + STEP;
            end
          end
        end
        ISSUE: begin
          brancherType <= 2'd0;
          state        <= WAIT;
        end
        WAIT: begin
          if (bus.BranchSignal) begin
            pcValue    <= bus.BranchAddress;
            flushPipe  <= 1'b1;
            flushCount <= FLUSH_LAST;
            if (takenCount != '1)
              takenCount <= takenCount + 1'b1;
            state <= FLUSH;
          end else begin
            pcValue    <= pcValue + STEP;
            stallFetch <= 1'b0;
            state      <= RUN;
          end
        end
        FLUSH: begin
          if (flushCount != 4'd0) begin
            flushCount <= flushCount - 4'd1;
          end else begin
            flushPipe  <= 1'b0;
            stallFetch <= 1'b0;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.IssueReady   = (state == RUN);
  assign bus.BrancherType = brancherType;
  assign bus.PCValue      = pcValue;
  assign bus.StallFetch   = stallFetch;
  assign bus.FlushPipe    = flushPipe;
  assign bus.TakenCount   = takenCount;
endmodule
